// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester slice.
// The optional ACCESS-phase abort is enabled with the APB_TIMEOUT_EN macro.
package apb_pkg;

  localparam int APB_ADDR_W         = 32;
  localparam int APB_DATA_W         = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS-phase wait states and flags the cycle on which the wait limit is reached.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic pclk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic limit_hit
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // limit_hit fires on the TIMEOUT_CYCLES-th consecutive wait cycle, not one later
  assign limit_hit = tick && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick && !limit_hit) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: one SETUP/ACCESS transfer per valid/ready command, response on valid/ready.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states with rsp_err=1.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETUP  = SETUP;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  logic [1:0] state;
  logic       wait_limit;

  assign cmd_ready = (state == S_IDLE) && !reset;

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .pclk      (pclk),
    .reset     (reset),
    .clear     (state != S_ACCESS),
    .tick      ((state == S_ACCESS) && !pready),
    .limit_hit (wait_limit)
  );
`else
  assign wait_limit = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // paddr/pwrite/pwdata are only loaded on accept, so they stay put through ACCESS and idle
  always_ff @(posedge pclk) begin
    if (reset) begin
      state     <= S_IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_wdata;
            psel   <= 1'b1;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready on the limit cycle still completes normally
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= S_RESP;
          end else if (wait_limit) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            rsp_err   <= 1'b1;
`endif
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef APB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
